// File: rtl/gppm_sequencer_if.sv
// Bundle of the sequencer's program-memory, datapath-control and run-status signals.
// The master side is the sequencer; the slave side is the memory/datapath environment.
interface gppm_sequencer_if #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
);
    logic              start;
    logic [PC_W-1:0]   imem_addr;
    logic [31:0]       imem_data;
    logic              isZero;
    logic [3:0]        raddr1;
    logic [3:0]        raddr2;
    logic [3:0]        waddr;
    logic [3:0]        func;
    logic              wen;
    logic              wdsrc;
    logic [31:0]       constant;
    logic              busy;
    logic              done;
    logic              err;
    logic [CNT_W-1:0]  icount;

    modport master (
        input  start, imem_data, isZero,
        output imem_addr, raddr1, raddr2, waddr, func, wen, wdsrc, constant,
               busy, done, err, icount
    );

    modport slave (
        output start, imem_data, isZero,
        input  imem_addr, raddr1, raddr2, waddr, func, wen, wdsrc, constant,
               busy, done, err, icount
    );
endinterface

// File: rtl/gppm_sequencer.sv
// Microcoded control sequencer: fetches 32-bit instructions from a combinational
// program memory and drives register/ALU datapath controls, with start/busy/done status.
module gppm_sequencer #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    gppm_sequencer_if.master  bus
);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ALU  = 4'd1;
    localparam logic [3:0] OP_LDI  = 4'd2;
    localparam logic [3:0] OP_JMP  = 4'd3;
    localparam logic [3:0] OP_BZ   = 4'd4;
    localparam logic [3:0] OP_BNZ  = 4'd5;
    localparam logic [3:0] OP_HALT = 4'd6;

    // IR keeps only the bits that are ever decoded: [31:12] plus the target field.
    localparam int IR_W = 20 + PC_W;

    localparam logic [PC_W-1:0]  PC_ZERO  = {PC_W{1'b0}};
    localparam logic [PC_W-1:0]  PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_IMM   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [PC_W-1:0]   pc_r;
    logic [PC_W-1:0]   pc_s;
    logic [IR_W-1:0]   ir_r;
    logic [IR_W-1:0]   ir_s;
    logic [CNT_W-1:0]  icount_r;
    logic [CNT_W-1:0]  icount_s;
    logic              err_r;
    logic              err_s;
    logic              busy_r;
    logic              done_r;

    logic              wen_s;
    logic              wdsrc_s;
    logic [31:0]       constant_s;

    logic [3:0]        ir_op_s;
    logic [3:0]        ir_waddr_s;
    logic [3:0]        ir_raddr1_s;
    logic [3:0]        ir_raddr2_s;
    logic [3:0]        ir_func_s;
    logic [PC_W-1:0]   ir_target_s;

    assign ir_op_s     = ir_r[IR_W-1  -: 4];
    assign ir_waddr_s  = ir_r[IR_W-5  -: 4];
    assign ir_raddr1_s = ir_r[IR_W-9  -: 4];
    assign ir_raddr2_s = ir_r[IR_W-13 -: 4];
    assign ir_func_s   = ir_r[IR_W-17 -: 4];
    assign ir_target_s = ir_r[PC_W-1:0];

    // Retired-instruction counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_ONE;
        end
    endfunction

    function automatic logic is_busy_state(input state_t s);
        is_busy_state = (s == ST_FETCH) || (s == ST_EXEC) || (s == ST_IMM);
    endfunction

    // Next-state, next-architectural-state and datapath control decode.
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        ir_s       = ir_r;
        icount_s   = icount_r;
        err_s      = err_r;
        wen_s      = 1'b0;
        wdsrc_s    = 1'b0;
        constant_s = 32'd0;

        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s  = ST_FETCH;
                    pc_s     = PC_ZERO;
                    icount_s = CNT_ZERO;
                    err_s    = 1'b0;
                end else begin
                    state_s  = ST_IDLE;
                end
            end

            ST_FETCH: begin
                ir_s    = {bus.imem_data[31:12], bus.imem_data[PC_W-1:0]};
                pc_s    = pc_r + PC_ONE;
                state_s = ST_EXEC;
            end

            ST_EXEC: begin
                case (ir_op_s)
                    OP_NOP: begin
                        icount_s = sat_inc(icount_r);
                        state_s  = ST_FETCH;
                    end
                    OP_ALU: begin
                        wen_s    = 1'b1;
                        wdsrc_s  = 1'b1;
                        icount_s = sat_inc(icount_r);
                        state_s  = ST_FETCH;
                    end
                    OP_LDI: begin
                        state_s  = ST_IMM;
                    end
                    OP_JMP: begin
                        pc_s     = ir_target_s;
                        icount_s = sat_inc(icount_r);
                        state_s  = ST_FETCH;
                    end
                    // isZero reflects the register file before this edge's write.
                    OP_BZ: begin
                        if (bus.isZero) begin
                            pc_s = ir_target_s;
                        end else begin
                            pc_s = pc_r;
                        end
                        icount_s = sat_inc(icount_r);
                        state_s  = ST_FETCH;
                    end
                    OP_BNZ: begin
                        if (!bus.isZero) begin
                            pc_s = ir_target_s;
                        end else begin
                            pc_s = pc_r;
                        end
                        icount_s = sat_inc(icount_r);
                        state_s  = ST_FETCH;
                    end
                    OP_HALT: begin
                        state_s  = ST_DONE;
                    end
                    default: begin
                        err_s    = 1'b1;
                        state_s  = ST_DONE;
                    end
                endcase
            end

            // Second LDI word is the immediate; pc wraps naturally at 2^PC_W.
            ST_IMM: begin
                constant_s = bus.imem_data;
                wen_s      = 1'b1;
                wdsrc_s    = 1'b0;
                pc_s       = pc_r + PC_ONE;
                icount_s   = sat_inc(icount_r);
                state_s    = ST_FETCH;
            end

            ST_DONE: begin
                state_s = ST_IDLE;
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, architectural registers and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            pc_r     <= PC_ZERO;
            ir_r     <= {IR_W{1'b0}};
            icount_r <= CNT_ZERO;
            err_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_s;
            ir_r     <= ir_s;
            icount_r <= icount_s;
            err_r    <= err_s;
            busy_r   <= is_busy_state(state_s);
            done_r   <= (state_s == ST_DONE);
        end
    end

    // wen decodes from the async-reset state, so reset kills a write immediately.
    assign bus.imem_addr = pc_r;
    assign bus.raddr1    = ir_raddr1_s;
    assign bus.raddr2    = ir_raddr2_s;
    assign bus.waddr     = ir_waddr_s;
    assign bus.func      = ir_func_s;
    assign bus.wen       = wen_s;
    assign bus.wdsrc     = wdsrc_s;
    assign bus.constant  = constant_s;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;
    assign bus.icount    = icount_r;

endmodule

// File: tb/tb_gppm_sequencer.sv
// Bench for gppm_sequencer: program memory + tiny datapath environment, an
// instruction-level reference interpreter producing a per-cycle expected trace.
module tb_gppm_sequencer;
    localparam int PC_W  = 8;
    localparam int CNT_W = 4;
    localparam logic [31:0] HALT_W = 32'h6000_0000;

    typedef struct packed {
        logic [7:0]  addr;
        logic [3:0]  r1;
        logic [3:0]  r2;
        logic [3:0]  wa;
        logic [3:0]  fn;
        logic        wen;
        logic        wdsrc;
        logic [31:0] cst;
        logic        busy;
        logic        done;
        logic        err;
        logic [3:0]  icount;
    } exp_t;

    logic clk;
    logic rst_n;
    logic env_clr;
    logic [31:0] prog [256];
    logic [31:0] env_regs [16];

    logic [7:0]  m_pc;
    logic [31:0] m_ir;
    logic [3:0]  m_icount;
    logic        m_err;
    logic [31:0] m_regs [16];
    exp_t        q [$];
    exp_t        idle_exp;
    bit          chk_en;
    int          total;
    int          bad;

    int          r_n;
    int          r_wens;
    logic [31:0] r_cst;
    logic [3:0]  r_wa;

    gppm_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    gppm_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] f);
        case (f)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return a;
        endcase
    endfunction

    assign bus.imem_data = prog[bus.imem_addr];
    assign bus.isZero = (alu(env_regs[bus.raddr1], env_regs[bus.raddr2], bus.func) == 32'd0);

    // Environment register file written by the sequencer's controls.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) env_regs[i] <= 32'd0;
        end else if (env_clr) begin
            for (int i = 0; i < 16; i++) env_regs[i] <= 32'd0;
        end else if (bus.wen) begin
            env_regs[bus.waddr] <= bus.wdsrc ? alu(env_regs[bus.raddr1], env_regs[bus.raddr2], bus.func)
                                             : bus.constant;
        end
    end

    function automatic exp_t mk(input logic [7:0] addr, input logic wen, input logic wdsrc,
                                input logic [31:0] cst, input logic busy, input logic done);
        exp_t e;
        e.addr = addr;       e.r1 = m_ir[23:20]; e.r2 = m_ir[19:16];
        e.wa = m_ir[27:24];  e.fn = m_ir[15:12];  e.wen = wen;
        e.wdsrc = wdsrc;     e.cst = cst;         e.busy = busy;
        e.done = done;       e.err = m_err;       e.icount = m_icount;
        return e;
    endfunction

    task automatic retire();
        m_icount = (m_icount == 4'hF) ? 4'hF : m_icount + 4'd1;
    endtask

    // Interpret the program from address 0 and queue the expected output of every cycle.
    task automatic model_run();
        logic [3:0]  op;
        logic [31:0] a;
        bit          z;
        m_pc = 8'd0; m_icount = 4'd0; m_err = 1'b0;
        for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
        q.delete();
        for (int guard = 0; guard < 2000; guard++) begin
            q.push_back(mk(m_pc, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0));
            m_ir = prog[m_pc];
            m_pc = m_pc + 8'd1;
            op = m_ir[31:28];
            a  = alu(m_regs[m_ir[23:20]], m_regs[m_ir[19:16]], m_ir[15:12]);
            z  = (a == 32'd0);
            q.push_back(mk(m_pc, op == 4'd1, op == 4'd1, 32'd0, 1'b1, 1'b0));
            if (op >= 4'd6) begin
                if (op != 4'd6) m_err = 1'b1;
                q.push_back(mk(m_pc, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1));
                break;
            end else if (op == 4'd2) begin
                q.push_back(mk(m_pc, 1'b1, 1'b0, prog[m_pc], 1'b1, 1'b0));
                m_regs[m_ir[27:24]] = prog[m_pc];
                m_pc = m_pc + 8'd1;
                retire();
            end else begin
                if (op == 4'd1) m_regs[m_ir[27:24]] = a;
                if (op == 4'd3 || (op == 4'd4 && z) || (op == 4'd5 && !z)) m_pc = m_ir[7:0];
                retire();
            end
        end
        idle_exp = mk(m_pc, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Single per-cycle compare of all DUT outputs against the interpreter trace.
    always @(negedge clk) begin : cmp
        exp_t e;
        exp_t a;
        if (chk_en) begin
            if (q.size() > 0) e = q.pop_front();
            else              e = idle_exp;
            a = {bus.imem_addr, bus.raddr1, bus.raddr2, bus.waddr, bus.func, bus.wen,
                 bus.wdsrc, bus.constant, bus.busy, bus.done, bus.err, bus.icount};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL cycle @%0t: got %h expected %h", $time, a, e);
            end
        end
    end

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = HALT_W;
    endtask

    task automatic launch();
        @(negedge clk); #1;
        model_run();
        env_clr = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        env_clr = 1'b0;
    endtask

    // Start a run and follow it to the done pulse; optionally toss stray start pulses.
    task automatic run(input bit rnd);
        launch();
        r_n = 0; r_wens = 0; r_cst = 32'd0; r_wa = 4'd0;
        for (int i = 1; i <= 600; i++) begin
            @(posedge clk); #1;
            if (bus.wen) begin
                r_wens++;
                if (!bus.wdsrc) begin r_cst = bus.constant; r_wa = bus.waddr; end
            end
            if (bus.done) begin
                r_n = i;
                bus.start = rnd ? ($urandom_range(0, 1) == 1) : 1'b0;
                break;
            end
            bus.start = rnd ? ($urandom_range(0, 2) == 0) : 1'b0;
        end
        if (r_n == 0) begin
            total++; bad++;
            $display("FAIL done_timeout: got no done expected done within 600 cycles");
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("trace_left", q.size(), 0);
    endtask

    task automatic gen_prog();
        int n;
        int k;
        logic [3:0]  op;
        logic [31:0] w;
        clear_prog();
        n = $urandom_range(6, 22);
        for (int i = 0; i < n - 1; i++) begin
            k = $urandom_range(0, 19);
            w = {4'd0, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                 4'($urandom_range(0, 3)), 4'($urandom_range(0, 5)), 12'd0};
            if (k < 3)       op = 4'd0;
            else if (k < 8)  op = 4'd1;
            else if (k < 11) op = 4'd2;
            else if (k < 13) op = 4'd3;
            else if (k < 15) op = 4'd4;
            else if (k < 17) op = 4'd5;
            else if (k < 18) op = 4'($urandom_range(7, 15));
            else             op = 4'd1;
            if (op == 4'd3 || op == 4'd4 || op == 4'd5) w[7:0] = 8'($urandom_range(i + 1, n - 1));
            if (op == 4'd2 && i + 1 >= n - 1) op = 4'd1;
            w[31:28] = op;
            prog[i] = w;
            if (op == 4'd2) begin
                prog[i + 1] = 32'($urandom_range(0, 3));
                i++;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; bus.start = 1'b0; env_clr = 1'b0; chk_en = 1'b0;
        total = 0; bad = 0;
        m_pc = 8'd0; m_ir = 32'd0; m_icount = 4'd0; m_err = 1'b0;
        idle_exp = mk(8'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        clear_prog();
        repeat (3) @(posedge clk);
        #1;
        check("rst_wen", bus.wen, 0);
        check("rst_busy", bus.busy, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        check("rst_addr", bus.imem_addr, 0);
        check("rst_icount", bus.icount, 0);

        // LDI r1,5 ; HALT
        prog[0] = 32'h2100_0000; prog[1] = 32'd5; prog[2] = HALT_W;
        run(1'b0);
        check("ldi_done_lat", r_n, 5);
        check("ldi_const", r_cst, 32'd5);
        check("ldi_waddr", r_wa, 4'd1);
        check("ldi_wens", r_wens, 1);
        check("ldi_icount", bus.icount, 1);

        // BZ taken (3-3) then not taken (3-4)
        clear_prog();
        prog[0] = 32'h2100_0000; prog[1] = 32'd3; prog[2] = 32'h2200_0000; prog[3] = 32'd3;
        prog[4] = 32'h1312_1000; prog[5] = 32'h4030_6007; prog[7] = 32'h0000_0000;
        run(1'b0);
        check("bz_taken_lat", r_n, 14);
        check("bz_taken_addr", bus.imem_addr, 9);
        check("bz_taken_icount", bus.icount, 5);
        prog[3] = 32'd4;
        run(1'b0);
        check("bz_fall_lat", r_n, 12);
        check("bz_fall_addr", bus.imem_addr, 7);
        check("bz_fall_icount", bus.icount, 4);

        // pc wraps 255 -> 0, then a second pass branches away
        clear_prog();
        prog[0] = 32'h5010_6002; prog[1] = 32'h3000_00FD; prog[253] = 32'h2100_0000;
        prog[254] = 32'd7; prog[255] = 32'h0000_0000; prog[2] = 32'h2200_0000; prog[3] = 32'd9;
        run(1'b0);
        check("wrap_lat", r_n, 16);
        check("wrap_addr", bus.imem_addr, 5);
        check("wrap_icount", bus.icount, 6);

        // LDI opcode at 255 takes its constant from address 0
        clear_prog();
        prog[0] = 32'h3000_00FF; prog[255] = 32'h2500_0000;
        run(1'b0);
        check("ldi_wrap_lat", r_n, 7);
        check("ldi_wrap_const", r_cst, 32'h3000_00FF);
        check("ldi_wrap_waddr", r_wa, 4'd5);
        check("ldi_wrap_addr", bus.imem_addr, 2);

        // Illegal opcode, then a clean run clears err
        clear_prog();
        prog[0] = 32'h9000_0000;
        run(1'b0);
        check("ill_lat", r_n, 2);
        check("ill_err", bus.err, 1);
        check("ill_wens", r_wens, 0);
        check("ill_icount", bus.icount, 0);
        prog[0] = HALT_W;
        run(1'b0);
        check("ill_err_clear", bus.err, 0);

        // Reset while LDI writes in IMM
        clear_prog();
        prog[0] = 32'h0; prog[1] = 32'h0; prog[2] = 32'h2100_0000; prog[3] = 32'd5;
        launch();
        repeat (6) @(posedge clk);
        #1;
        check("imm_wen", bus.wen, 1);
        check("imm_const", bus.constant, 32'd5);
        check("imm_icount", bus.icount, 2);
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_wen", bus.wen, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_icount", bus.icount, 0);
        check("arst_addr", bus.imem_addr, 0);
        q.delete();
        m_pc = 8'd0; m_ir = 32'd0; m_icount = 4'd0; m_err = 1'b0;
        idle_exp = mk(8'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);

        // Stray start pulses while busy change nothing
        clear_prog();
        prog[0] = 32'h2100_0000; prog[1] = 32'd5;
        run(1'b1);
        check("busy_start_lat", r_n, 5);
        check("busy_start_icount", bus.icount, 1);

        // 20 NOPs saturate the 4-bit counter
        clear_prog();
        for (int i = 0; i < 20; i++) prog[i] = 32'h0;
        run(1'b0);
        check("sat_icount", bus.icount, 4'hF);
        check("sat_lat", r_n, 42);

        for (int t = 0; t < 40; t++) begin
            gen_prog();
            run(1'b1);
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
